ex_alu_branch_unit: RTL and testbench
=====================================

Name: ex_alu_branch_unit

Overview:
- Execute-stage datapath block for the pipelined MIPS-subset processor.
- Contains three parts:
  - a 32-bit ALU with zero and negative flags;
  - a PC+4 incrementer;
  - a branch condition evaluator that decides branch-taken from the opcode, the rt field, the B_instr control bit and the ALU flags.
- Main outputs are combinational. Flag and taken registers (1-cycle latency) feed downstream pipeline logic.

Parameters:
- WIDTH, 32, datapath width of A, B, result and PC.

Ports:
- clk  input  1  clock; all registers update on the rising edge.
- reset  input  1  synchronous, active-low reset.
- alu_op  input  4  ALU operation select.
- a  input  WIDTH  ALU operand A (rs path).
- b  input  WIDTH  ALU operand B (output of the operand-2 handler).
- alu_out  output  WIDTH  combinational ALU result.
- z  output  1  combinational zero flag: alu_out == 0.
- n  output  1  combinational negative flag: alu_out[WIDTH-1].
- pc_in  input  WIDTH  current PC.
- pc_plus4  output  WIDTH  combinational pc_in + 4.
- b_instr  input  1  branch-instruction control bit from the EX control word.
- opcode  input  6  instruction[31:26] in EX.
- rt  input  5  instruction[20:16] in EX.
- taken  output  1  combinational branch-taken decision.
- flags_le  input  1  load enable for the flag register.
- z_q  output  1  registered z.
- n_q  output  1  registered n.
- taken_q  output  1  registered taken.

Behaviour:
- ALU (combinational, unsigned wrap modulo 2^32 unless stated):
  - 0000 A+B
  - 0001 A-B
  - 0010 A&B
  - 0011 A|B
  - 0100 A^B
  - 0101 ~(A|B)
  - 0110 B<<A[4:0] (logical)
  - 0111 B>>A[4:0] (logical)
  - 1000 B>>>A[4:0] (arithmetic, sign-fill)
  - 1001 signed A<B ? 1 : 0
  - 1010 unsigned A<B ? 1 : 0
  - 1011 pass A
  - 1100 pass B
  - 1101 B<<16 (LUI)
  - 1110, 1111: result 0
- Shift amounts use only A[4:0]; A[31:5] is ignored.
- z and n are always derived from alu_out for every op, including the set-less-than ops and the undefined codes (undefined codes give z=1, n=0).
- Incrementer: pc_plus4 = pc_in + 4, wrapping (0xFFFFFFFC -> 0x00000000). It is independent of every other input.
- Branch evaluation: taken = b_instr AND cond, where cond depends on opcode:
  - 000100 BEQ: z
  - 000101 BNE: !z
  - 000110 BLEZ: z | n
  - 000111 BGTZ: !z & !n
  - 000001 REGIMM, by rt:
    - 00000 BLTZ and 10000 BLTZAL: n
    - 00001 BGEZ and 10001 BGEZAL: !n
    - any other rt: 0
  - any other opcode: 0
- For BEQ/BNE, the control unit programs alu_op = 0001 (A-B). For single-operand branches it programs 1011 (pass A). This block does not override alu_op.
- b_instr = 0 forces taken = 0 regardless of opcode and flags.
- Registers, on the rising clk edge:
  - reset = 0: z_q, n_q and taken_q all clear to 0. Reset has priority over flags_le.
  - otherwise, if flags_le = 1: z_q <= z and n_q <= n.
  - if flags_le = 0: z_q and n_q hold.
  - taken_q <= taken every cycle (not gated by flags_le).
- Reset has no effect on the combinational outputs. While reset is held, alu_out, z, n, pc_plus4 and taken keep tracking their inputs.
- Latency: combinational outputs 0 cycles; registered outputs 1 cycle.
- No X propagation from unused inputs: opcode and rt affect only taken.

Test Plan:
1. ALU add overflow: alu_op=0000, a=0x7FFFFFFF, b=1 -> alu_out=0x80000000, n=1, z=0. Then sub with a=5, b=5 -> alu_out=0, z=1, n=0.
2. Shifts, LUI and set-less-than:
   - 1000 with a=4, b=0x80000000 -> 0xF8000000.
   - 0111, same inputs -> 0x08000000.
   - 1101 with b=0x1234 -> 0x12340000.
   - 1001 with a=0xFFFFFFFF, b=1 -> 1.
   - 1010, same inputs -> 0.
3. Incrementer: pc_in=0x00000008 -> pc_plus4=0x0000000C; pc_in=0xFFFFFFFC -> pc_plus4=0x00000000.
4. Branches (b_instr=1):
   - BEQ, a=b=7, op 0001 -> taken=1.
   - BNE, same inputs -> 0.
   - BGTZ, a=3, op 1011 -> 1.
   - BGTZ, a=0 -> 0.
   - REGIMM rt=00000, a=0xFFFFFFFF -> 1.
   - REGIMM rt=00010 -> 0.
   - Any case above with b_instr=0 -> taken=0.
5. Registers:
   - reset=0 for one edge -> z_q=n_q=taken_q=0.
   - Release reset, flags_le=1, result 0 -> next edge z_q=1.
   - flags_le=0, result negative -> z_q stays 1, n_q stays 0.
   - taken_q follows taken with a 1-cycle delay.
6. Reset priority: reset=0 and flags_le=1 on the same edge while z=1 -> z_q=0. Combinational alu_out remains valid during reset.

Source files
------------

// File: rtl/ex_alu_branch_unit.sv
// Execute-stage datapath: 32-bit ALU with zero/negative flags, PC+4
// incrementer, branch condition evaluator, and the pipeline flag/taken
// registers that feed downstream logic.
module ex_alu_branch_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] alu_out,
    output logic             z,
    output logic             n,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_plus4,
    input  logic             b_instr,
    input  logic [5:0]       opcode,
    input  logic [4:0]       rt,
    output logic             taken,
    input  logic             flags_le,
    output logic             z_q,
    output logic             n_q,
    output logic             taken_q
);

    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned LUI_SH  = 16;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_PASA = 4'b1011;
    localparam logic [3:0] OP_PASB = 4'b1100;
    localparam logic [3:0] OP_LUI  = 4'b1101;

    localparam logic [5:0] OPC_REGIMM = 6'b000001;
    localparam logic [5:0] OPC_BEQ    = 6'b000100;
    localparam logic [5:0] OPC_BNE    = 6'b000101;
    localparam logic [5:0] OPC_BLEZ   = 6'b000110;
    localparam logic [5:0] OPC_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    logic [SHAMT_W-1:0] shamt;
    logic               slt_s;
    logic               slt_u;
    logic               cond;

    // Only the low five bits of A are a shift amount; upper bits are ignored.
    assign shamt = a[SHAMT_W-1:0];
    assign slt_s = $signed(a) < $signed(b);
    assign slt_u = a < b;

    // ALU result selection; undefined codes yield zero.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            OP_ADD:  alu_out = a + b;
            OP_SUB:  alu_out = a - b;
            OP_AND:  alu_out = a & b;
            OP_OR:   alu_out = a | b;
            OP_XOR:  alu_out = a ^ b;
            OP_NOR:  alu_out = ~(a | b);
            OP_SLL:  alu_out = b << shamt;
            OP_SRL:  alu_out = b >> shamt;
            OP_SRA:  alu_out = WIDTH'($signed(b) >>> shamt);
            OP_SLT:  alu_out = WIDTH'(slt_s);
            OP_SLTU: alu_out = WIDTH'(slt_u);
            OP_PASA: alu_out = a;
            OP_PASB: alu_out = b;
            OP_LUI:  alu_out = b << LUI_SH;
            default: alu_out = '0;
        endcase
    end

    assign z        = (alu_out == '0);
    assign n        = alu_out[WIDTH-1];
    assign pc_plus4 = pc_in + WIDTH'(4);

    // Branch condition from opcode (and rt for REGIMM) over the ALU flags.
    always_comb begin
        cond = 1'b0;
        case (opcode)
            OPC_BEQ:  cond = z;
            OPC_BNE:  cond = ~z;
            OPC_BLEZ: cond = z | n;
            OPC_BGTZ: cond = ~z & ~n;
            OPC_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BLTZAL: cond = n;
                    RT_BGEZ, RT_BGEZAL: cond = ~n;
                    default:            cond = 1'b0;
                endcase
            end
            default:  cond = 1'b0;
        endcase
    end

    assign taken = b_instr & cond;

    // Flag register (load-enabled) and taken register (every cycle); reset wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            if (flags_le) begin
                z_q <= z;
                n_q <= n;
            end
            taken_q <= taken;
        end
    end

endmodule

// File: tb/tb_ex_alu_branch_unit.sv
// Directed self-checking bench for ex_alu_branch_unit.
module tb_ex_alu_branch_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_out;
    logic        z;
    logic        n;
    logic [31:0] pc_in;
    logic [31:0] pc_plus4;
    logic        b_instr;
    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic        taken;
    logic        flags_le;
    logic        z_q;
    logic        n_q;
    logic        taken_q;

    int checks   = 0;
    int failures = 0;

    ex_alu_branch_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .alu_op   (alu_op),
        .a        (a),
        .b        (b),
        .alu_out  (alu_out),
        .z        (z),
        .n        (n),
        .pc_in    (pc_in),
        .pc_plus4 (pc_plus4),
        .b_instr  (b_instr),
        .opcode   (opcode),
        .rt       (rt),
        .taken    (taken),
        .flags_le (flags_le),
        .z_q      (z_q),
        .n_q      (n_q),
        .taken_q  (taken_q)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        alu_op = op;
        a      = va;
        b      = vb;
        #1;
    endtask

    task automatic br(input logic bi, input logic [5:0] opc, input logic [4:0] vrt,
                      input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        b_instr = bi;
        opcode  = opc;
        rt      = vrt;
        alu(op, va, vb);
    endtask

    initial begin
        reset    = 1'b0;
        flags_le = 1'b1;
        alu_op   = 4'b0000;
        a        = 32'h0;
        b        = 32'h0;
        pc_in    = 32'h0;
        b_instr  = 1'b0;
        opcode   = 6'b000000;
        rt       = 5'b00000;

        // Reset edge with z=1 and flags_le=1: reset must win.
        @(posedge clk); #1;
        check("rst_z_q", z_q, 1'b0);
        check("rst_n_q", n_q, 1'b0);
        check("rst_taken_q", taken_q, 1'b0);
        check("rst_comb_z", z, 1'b1);
        alu(4'b0000, 32'd3, 32'd4);
        check("rst_comb_alu", alu_out, 32'd7);

        // ALU operations.
        alu(4'b0000, 32'h7FFF_FFFF, 32'h1);
        check("add_ovf", alu_out, 32'h8000_0000);
        check("add_ovf_n", n, 1'b1);
        check("add_ovf_z", z, 1'b0);
        alu(4'b0001, 32'd5, 32'd5);
        check("sub_zero", alu_out, 32'h0);
        check("sub_z", z, 1'b1);
        check("sub_n", n, 1'b0);
        alu(4'b0010, 32'h0000_F0F0, 32'h0000_FF00);
        check("and", alu_out, 32'h0000_F000);
        alu(4'b0011, 32'h0000_F0F0, 32'h0000_FF00);
        check("or", alu_out, 32'h0000_FFF0);
        alu(4'b0100, 32'h0000_F0F0, 32'h0000_FF00);
        check("xor", alu_out, 32'h0000_0FF0);
        alu(4'b0101, 32'h0, 32'h0);
        check("nor", alu_out, 32'hFFFF_FFFF);
        alu(4'b0110, 32'h0000_0021, 32'h1);
        check("sll_shamt_mask", alu_out, 32'h2);
        alu(4'b1000, 32'd4, 32'h8000_0000);
        check("sra", alu_out, 32'hF800_0000);
        alu(4'b0111, 32'd4, 32'h8000_0000);
        check("srl", alu_out, 32'h0800_0000);
        alu(4'b1101, 32'h0, 32'h0000_1234);
        check("lui", alu_out, 32'h1234_0000);
        alu(4'b1001, 32'hFFFF_FFFF, 32'h1);
        check("slt", alu_out, 32'h1);
        alu(4'b1010, 32'hFFFF_FFFF, 32'h1);
        check("sltu", alu_out, 32'h0);
        check("sltu_z", z, 1'b1);
        alu(4'b1011, 32'hDEAD_BEEF, 32'h1);
        check("pass_a", alu_out, 32'hDEAD_BEEF);
        alu(4'b1100, 32'h1, 32'hCAFE_0001);
        check("pass_b", alu_out, 32'hCAFE_0001);
        alu(4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("undef_out", alu_out, 32'h0);
        check("undef_z", z, 1'b1);
        check("undef_n", n, 1'b0);

        // Incrementer.
        pc_in = 32'h0000_0008; #1;
        check("pc4", pc_plus4, 32'h0000_000C);
        pc_in = 32'hFFFF_FFFC; #1;
        check("pc4_wrap", pc_plus4, 32'h0000_0000);

        // Branch evaluation.
        br(1'b1, 6'b000100, 5'd0, 4'b0001, 32'd7, 32'd7);
        check("beq_eq", taken, 1'b1);
        br(1'b1, 6'b000101, 5'd0, 4'b0001, 32'd7, 32'd7);
        check("bne_eq", taken, 1'b0);
        br(1'b1, 6'b000110, 5'd0, 4'b1011, 32'd0, 32'd0);
        check("blez_zero", taken, 1'b1);
        br(1'b1, 6'b000111, 5'd0, 4'b1011, 32'd3, 32'd0);
        check("bgtz_pos", taken, 1'b1);
        br(1'b1, 6'b000111, 5'd0, 4'b1011, 32'd0, 32'd0);
        check("bgtz_zero", taken, 1'b0);
        br(1'b1, 6'b000001, 5'b00000, 4'b1011, 32'hFFFF_FFFF, 32'd0);
        check("bltz_neg", taken, 1'b1);
        br(1'b1, 6'b000001, 5'b00010, 4'b1011, 32'hFFFF_FFFF, 32'd0);
        check("regimm_bad_rt", taken, 1'b0);
        br(1'b1, 6'b000001, 5'b10001, 4'b1011, 32'd5, 32'd0);
        check("bgezal_pos", taken, 1'b1);
        br(1'b0, 6'b000100, 5'd0, 4'b0001, 32'd7, 32'd7);
        check("beq_no_binstr", taken, 1'b0);
        br(1'b1, 6'b000010, 5'd0, 4'b0001, 32'd7, 32'd7);
        check("bad_opcode", taken, 1'b0);

        // Flag and taken registers.
        @(negedge clk);
        reset    = 1'b1;
        flags_le = 1'b1;
        br(1'b1, 6'b000100, 5'd0, 4'b0001, 32'd7, 32'd7);
        @(posedge clk); #1;
        check("load_z_q", z_q, 1'b1);
        check("load_n_q", n_q, 1'b0);
        check("taken_q_1", taken_q, 1'b1);

        @(negedge clk);
        flags_le = 1'b0;
        br(1'b1, 6'b000100, 5'd0, 4'b1011, 32'h8000_0000, 32'd0);
        @(posedge clk); #1;
        check("hold_z_q", z_q, 1'b1);
        check("hold_n_q", n_q, 1'b0);
        check("taken_q_0", taken_q, 1'b0);

        @(negedge clk);
        flags_le = 1'b1;
        @(posedge clk); #1;
        check("reload_z_q", z_q, 1'b0);
        check("reload_n_q", n_q, 1'b1);

        // Reset priority over flags_le; combinational paths stay live.
        @(negedge clk);
        reset    = 1'b0;
        flags_le = 1'b1;
        br(1'b1, 6'b000100, 5'd0, 4'b0001, 32'd7, 32'd7);
        check("rstp_alu", alu_out, 32'h0);
        check("rstp_taken", taken, 1'b1);
        @(posedge clk); #1;
        check("rstp_z_q", z_q, 1'b0);
        check("rstp_n_q", n_q, 1'b0);
        check("rstp_taken_q", taken_q, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
